// File: rtl/mbist_sched_if.sv
// Handshake bundle between the MBIST scheduler, the SoC test controller and the shared engine.
// The slave modport is the scheduler's view; master is the controller/engine side.
interface mbist_sched_if #(
   parameter int unsigned NUM_MEM = 4,
   parameter int unsigned SEL_W   = 2
);
   logic               start;
   logic               abort;
   logic [NUM_MEM-1:0] mem_mask;
   logic               bist_done;
   logic               fault_flag;
   logic               bist_rst_n;
   logic               bist_mode;
   logic [SEL_W-1:0]   mem_sel;
   logic               busy;
   logic               done;
   logic               pass;
   logic               aborted;
   logic [NUM_MEM-1:0] fault_map;
   logic [NUM_MEM-1:0] tmo_map;

   modport master (
      output start, abort, mem_mask, bist_done, fault_flag,
      input  bist_rst_n, bist_mode, mem_sel, busy, done, pass, aborted, fault_map, tmo_map
   );

   modport slave (
      input  start, abort, mem_mask, bist_done, fault_flag,
      output bist_rst_n, bist_mode, mem_sel, busy, done, pass, aborted, fault_map, tmo_map
   );
endinterface

// File: rtl/mbist_sched.sv
// Runs one shared MBIST engine over each enabled memory in ascending order and
// collects per-memory fault/timeout maps plus an overall pass/done result.
module mbist_sched #(
   parameter int unsigned         NUM_MEM = 4,
   parameter int unsigned         SEL_W   = 2,
   parameter int unsigned         RST_CYC = 2,
   parameter int unsigned         TMO_W   = 16,
   parameter logic [TMO_W-1:0]    TMO_MAX = 16'hFFFF
) (
   input  logic          clk,
   input  logic          rst,
   mbist_sched_if.slave  bus
);
   localparam int unsigned      PTR_W    = $clog2(NUM_MEM + 1);
   localparam int unsigned      CNT_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StScan   = 3'd1;
   localparam logic [2:0] StRst    = 3'd2;
   localparam logic [2:0] StRun    = 3'd3;
   localparam logic [2:0] StDrain  = 3'd4;
   localparam logic [2:0] StFinish = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_MEM-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;
   logic               bist_rst_n_q, bist_rst_n_d;
   logic               bist_mode_q, bist_mode_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               aborted_q, aborted_d;
   logic [NUM_MEM-1:0] fault_map_q, fault_map_d;
   logic [NUM_MEM-1:0] tmo_map_q, tmo_map_d;

   logic [NUM_MEM-1:0] mask_sh;
   logic [NUM_MEM-1:0] ptr_bit;
   logic               abort_ok;

   // Shifts avoid indexing past the mask when ptr reaches NUM_MEM.
   assign mask_sh  = mask_q >> ptr_q;
   assign ptr_bit  = NUM_MEM'(1) << ptr_q;
   assign abort_ok = bus.abort && (state_q inside {StScan, StRst, StRun, StDrain});

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      mem_sel_d   = mem_sel_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      aborted_d   = aborted_q;
      fault_map_d = fault_map_q;
      tmo_map_d   = tmo_map_q;

      if (abort_ok) begin
         aborted_d = 1'b1;
         state_d   = StFinish;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  mask_d      = bus.mem_mask;
                  ptr_d       = '0;
                  fault_map_d = '0;
                  tmo_map_d   = '0;
                  pass_d      = 1'b0;
                  aborted_d   = 1'b0;
                  busy_d      = 1'b1;
                  state_d     = StScan;
               end
            end
            StScan: begin
               if (ptr_q == PTR_W'(NUM_MEM)) begin
                  state_d = StFinish;
               end else if (mask_sh[0]) begin
                  mem_sel_d = SEL_W'(ptr_q);
                  cnt_d     = CNT_W'(RST_CYC - 1);
                  state_d   = StRst;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
            StRst: begin
               if (cnt_q == '0) begin
                  tmo_d   = '0;
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StRun: begin
               // A completion landing on the last timeout cycle is not a timeout.
               if (bus.bist_done) begin
                  if (bus.fault_flag) fault_map_d = fault_map_q | ptr_bit;
                  state_d = StDrain;
               end else if (tmo_q == TMO_LAST) begin
                  fault_map_d = fault_map_q | ptr_bit;
                  tmo_map_d   = tmo_map_q | ptr_bit;
                  state_d     = StDrain;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            StDrain: begin
               ptr_d   = ptr_q + 1'b1;
               state_d = StScan;
            end
            StFinish: begin
               done_d  = 1'b1;
               pass_d  = ~|fault_map_q & ~aborted_q;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Engine controls track the upcoming state so they flip with the state register.
      bist_mode_d  = (state_d == StRun);
      bist_rst_n_d = (state_d == StRun);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         mask_q       <= '0;
         cnt_q        <= '0;
         tmo_q        <= '0;
         mem_sel_q    <= '0;
         bist_rst_n_q <= 1'b0;
         bist_mode_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         aborted_q    <= 1'b0;
         fault_map_q  <= '0;
         tmo_map_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         mask_q       <= mask_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         mem_sel_q    <= mem_sel_d;
         bist_rst_n_q <= bist_rst_n_d;
         bist_mode_q  <= bist_mode_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         aborted_q    <= aborted_d;
         fault_map_q  <= fault_map_d;
         tmo_map_q    <= tmo_map_d;
      end
   end

   assign bus.bist_rst_n = bist_rst_n_q;
   assign bus.bist_mode  = bist_mode_q;
   assign bus.mem_sel    = mem_sel_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.aborted    = aborted_q;
   assign bus.fault_map  = fault_map_q;
   assign bus.tmo_map    = tmo_map_q;
endmodule

// File: tb/tb_mbist_sched.sv
// Directed bench for mbist_sched: the bench plays the MBIST engine with a per-vector
// latency, fault and hang profile, and checks maps, pass, latency and corner sequences.
module tb_mbist_sched;
   logic clk;
   logic rst;

   mbist_sched_if #(.NUM_MEM(4), .SEL_W(2)) bus ();

   mbist_sched #(
      .NUM_MEM (4),
      .SEL_W   (2),
      .RST_CYC (2),
      .TMO_W   (16),
      .TMO_MAX (16'd64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      logic [3:0] faults;
      logic [3:0] hang;
      int         lat;
      logic [3:0] exp_fmap;
      logic [3:0] exp_tmap;
      logic       exp_pass;
      int         exp_cyc;
      logic [1:0] exp_sel;
   } vec_t;

   vec_t       vecs[9];
   int         checks;
   int         errors;
   int         run_cnt;
   int         lat_cur;
   logic [3:0] fault_cur;
   logic [3:0] hang_cur;
   logic [3:0] visited;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: wait for the falling edge, sample, then drive the engine response.
   task automatic tick();
      @(negedge clk);
      if (bus.bist_mode) begin
         run_cnt++;
         if (run_cnt == 1) visited = visited | (4'b0001 << bus.mem_sel);
         bus.bist_done  = !hang_cur[bus.mem_sel] && (run_cnt == lat_cur);
         bus.fault_flag = bus.bist_done && fault_cur[bus.mem_sel];
      end else begin
         run_cnt        = 0;
         bus.bist_done  = 1'b0;
         bus.fault_flag = 1'b0;
      end
   endtask

   task automatic start_seq(input logic [3:0] m);
      tick();
      visited      = 4'b0000;
      bus.start    = 1'b1;
      bus.mem_mask = m;
   endtask

   task automatic wait_done(input int base, output int cyc, output bit ok);
      cyc = base;
      ok  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         bus.start = 1'b0;
         cyc++;
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int   cyc;
      bit   ok;
      int   dones;
      logic [31:0] mode_seen;

      checks = 0;
      errors = 0;
      run_cnt = 0;
      lat_cur = 40;
      fault_cur = '0;
      hang_cur = '0;
      visited = '0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mem_mask = '0;
      bus.bist_done = 1'b0;
      bus.fault_flag = 1'b0;

      //              mask     faults   hang     lat fmap     tmap     pass cyc  sel
      vecs[0] = '{4'b1111, 4'b0000, 4'b0000, 40, 4'b0000, 4'b0000, 1'b1, 179, 2'd3};
      vecs[1] = '{4'b0101, 4'b0100, 4'b0000, 40, 4'b0100, 4'b0000, 1'b0, 93,  2'd2};
      vecs[2] = '{4'b0011, 4'b0000, 4'b0010, 40, 4'b0010, 4'b0010, 1'b0, 117, 2'd1};
      vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 40, 4'b0000, 4'b0000, 1'b1, 7,   2'd1};
      vecs[4] = '{4'b1000, 4'b1000, 4'b0000, 3,  4'b1000, 4'b0000, 1'b0, 13,  2'd3};
      vecs[5] = '{4'b1010, 4'b0010, 4'b1000, 5,  4'b1010, 4'b1000, 1'b0, 82,  2'd3};
      vecs[6] = '{4'b0001, 4'b0000, 4'b0000, 64, 4'b0000, 4'b0000, 1'b1, 74,  2'd0};
      vecs[7] = '{4'b0001, 4'b0001, 4'b0000, 64, 4'b0001, 4'b0000, 1'b0, 74,  2'd0};
      vecs[8] = '{4'b0100, 4'b0000, 4'b0000, 1,  4'b0000, 4'b0000, 1'b1, 11,  2'd2};

      repeat (3) tick();
      chk("reset bist_rst_n", {31'd0, bus.bist_rst_n}, 32'd0);
      chk("reset bist_mode",  {31'd0, bus.bist_mode},  32'd0);
      chk("reset busy",       {31'd0, bus.busy},       32'd0);
      chk("reset done",       {31'd0, bus.done},       32'd0);
      chk("reset pass",       {31'd0, bus.pass},       32'd0);
      chk("reset aborted",    {31'd0, bus.aborted},    32'd0);
      chk("reset mem_sel",    {30'd0, bus.mem_sel},    32'd0);
      chk("reset fault_map",  {28'd0, bus.fault_map},  32'd0);
      chk("reset tmo_map",    {28'd0, bus.tmo_map},    32'd0);
      rst = 1'b0;
      tick();

      // Engine noise and abort while idle must leave everything untouched.
      bus.bist_done  = 1'b1;
      bus.fault_flag = 1'b1;
      bus.abort      = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      tick();
      chk("idle noise busy",      {31'd0, bus.busy},      32'd0);
      chk("idle noise fault_map", {28'd0, bus.fault_map}, 32'd0);
      chk("idle noise aborted",   {31'd0, bus.aborted},   32'd0);
      chk("idle noise bist_rst_n", {31'd0, bus.bist_rst_n}, 32'd0);

      for (int v = 0; v < 9; v++) begin
         lat_cur   = vecs[v].lat;
         fault_cur = vecs[v].faults;
         hang_cur  = vecs[v].hang;
         start_seq(vecs[v].mask);
         wait_done(0, cyc, ok);
         chk($sformatf("v%0d done seen", v), {31'd0, ok}, 32'd1);
         chk($sformatf("v%0d latency", v), cyc, vecs[v].exp_cyc);
         chk($sformatf("v%0d fault_map", v), {28'd0, bus.fault_map}, {28'd0, vecs[v].exp_fmap});
         chk($sformatf("v%0d tmo_map", v), {28'd0, bus.tmo_map}, {28'd0, vecs[v].exp_tmap});
         chk($sformatf("v%0d pass", v), {31'd0, bus.pass}, {31'd0, vecs[v].exp_pass});
         chk($sformatf("v%0d aborted", v), {31'd0, bus.aborted}, 32'd0);
         chk($sformatf("v%0d visited", v), {28'd0, visited}, {28'd0, vecs[v].mask});
         chk($sformatf("v%0d busy at done", v), {31'd0, bus.busy}, 32'd0);
         chk($sformatf("v%0d mem_sel", v), {30'd0, bus.mem_sel}, {30'd0, vecs[v].exp_sel});
         tick();
         chk($sformatf("v%0d done width", v), {31'd0, bus.done}, 32'd0);
      end

      // Start while busy: the second request and its mask are dropped.
      lat_cur = 10; fault_cur = '0; hang_cur = '0;
      start_seq(4'b0001);
      tick();
      bus.start    = 1'b0;
      tick();
      bus.start    = 1'b1;
      bus.mem_mask = 4'b1110;
      wait_done(2, cyc, ok);
      chk("busy start done seen", {31'd0, ok}, 32'd1);
      chk("busy start latency", cyc, 32'd20);
      chk("busy start visited", {28'd0, visited}, 32'h1);
      chk("busy start pass", {31'd0, bus.pass}, 32'd1);
      wait_done(0, cyc, ok);
      chk("busy start no rerun", {31'd0, ok}, 32'd0);

      // Abort during RUN of memory 1.
      lat_cur = 40;
      start_seq(4'b1111);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick();
         bus.start = 1'b0;
         if (bus.bist_mode && bus.mem_sel == 2'd1 && run_cnt == 5) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort reached mem1 run", {31'd0, ok}, 32'd1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort bist_mode drop", {31'd0, bus.bist_mode}, 32'd0);
      chk("abort busy in finish", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("abort done", {31'd0, bus.done}, 32'd1);
      chk("abort aborted", {31'd0, bus.aborted}, 32'd1);
      chk("abort pass", {31'd0, bus.pass}, 32'd0);
      chk("abort fault_map", {28'd0, bus.fault_map}, 32'd0);
      chk("abort visited", {28'd0, visited}, 32'h3);

      // Synchronous reset in the middle of RUN.
      start_seq(4'b1111);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         bus.start = 1'b0;
         if (bus.bist_mode) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst reached run", {31'd0, ok}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst bist_rst_n", {31'd0, bus.bist_rst_n}, 32'd0);
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst bist_mode", {31'd0, bus.bist_mode}, 32'd0);
      chk("rst aborted", {31'd0, bus.aborted}, 32'd0);
      dones = 0;
      mode_seen = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.done) dones++;
         if (bus.bist_mode) mode_seen++;
      end
      chk("rst no done", dones, 32'd0);
      chk("rst engine quiet", mode_seen, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
